// File: rtl/bit_unpacker.sv
// Word FIFO feeding a variable-length bit extractor (LSB-first stream by default).
// Define BITS_MSB_FIRST_EN to read each word from bit IN_W-1 down and shift results in MSB-first.
module bit_unpacker #(
  parameter int IN_W    = 32,
  parameter int DEPTH   = 32,
  parameter int MAX_REQ = 15,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = $clog2(DEPTH*IN_W+1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pushin,
  input  logic [IN_W-1:0]    datain,
  input  logic               reqin,
  input  logic [LEN_W-1:0]   reqlen,
  output logic               reqbusy,
  output logic               pushout,
  output logic [LEN_W-1:0]   lenout,
  output logic [MAX_REQ-1:0] dataout,
  output logic               fullout,
  output logic [CNT_W-1:0]   bitcnt,
  output logic               overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int OFF_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int SUM_W = ((OFF_W+1 > LEN_W) ? OFF_W+1 : LEN_W) + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_REQ);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [OFF_W-1:0]   bitoff_q, bitoff_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic               fullout_q, overflow_q, pushout_q;
  logic [LEN_W-1:0]   lenout_q;
  logic [MAX_REQ-1:0] dataout_q;

  logic [IN_W-1:0]    mem_q [DEPTH];
  logic [IN_W-1:0]    head, nxt;
  logic [2*IN_W-1:0]  win;
  logic [MAX_REQ-1:0] extract;
  logic [SUM_W-1:0]   sum;
  logic               push_ok, serve, pop;

  assign push_ok = pushin && !fullout_q;
  assign serve   = (state_q == S_WAIT) && (bitcnt_q >= CNT_W'(len_q));
  assign sum     = SUM_W'(bitoff_q) + SUM_W'(len_q);
  assign pop     = serve && (sum >= SUM_W'(IN_W));

  // The next word is only looked at when the request runs past the head word,
  // and in that case enough bits guarantee it has been written.
  assign head = mem_q[rd_q];
  assign nxt  = mem_q[rd_q + 1'b1];

`ifdef BITS_MSB_FIRST_EN
  assign win     = {head, nxt} << bitoff_q;
  assign extract = win[2*IN_W-1 -: MAX_REQ] >> (MAX_LEN - len_q);
`else
  assign win     = {nxt, head} >> bitoff_q;
  assign extract = win[MAX_REQ-1:0] & ~({MAX_REQ{1'b1}} << len_q);
`endif

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    bitoff_d = bitoff_q;
    count_d  = count_q;
    bitcnt_d = bitcnt_q;
    case (state_q)
      S_IDLE: begin
        if (reqin) begin
          len_d   = (reqlen > MAX_LEN) ? MAX_LEN : reqlen;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (serve) begin
          state_d  = S_IDLE;
          bitcnt_d = bitcnt_d - CNT_W'(len_q);
          if (pop) begin
            rd_d     = rd_q + 1'b1;
            bitoff_d = OFF_W'(sum - SUM_W'(IN_W));
            count_d  = count_d - 1'b1;
          end else begin
            bitoff_d = OFF_W'(sum);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (push_ok) begin
      wr_d     = wr_q + 1'b1;
      count_d  = count_d + 1'b1;
      bitcnt_d = bitcnt_d + CNT_W'(IN_W);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_q] <= datain;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      bitoff_q   <= '0;
      count_q    <= '0;
      bitcnt_q   <= '0;
      fullout_q  <= 1'b0;
      overflow_q <= 1'b0;
      pushout_q  <= 1'b0;
      lenout_q   <= '0;
      dataout_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      bitoff_q  <= bitoff_d;
      count_q   <= count_d;
      bitcnt_q  <= bitcnt_d;
      fullout_q <= (count_d == CW'(DEPTH));
      pushout_q <= serve;
      if (pushin && fullout_q) overflow_q <= 1'b1;
      // Results hold between services.
      if (serve) begin
        lenout_q  <= len_q;
        dataout_q <= extract;
      end
    end
  end

  assign reqbusy  = (state_q == S_WAIT);
  assign pushout  = pushout_q;
  assign lenout   = lenout_q;
  assign dataout  = dataout_q;
  assign fullout  = fullout_q;
  assign bitcnt   = bitcnt_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bit_unpacker.sv
// Directed self-checking bench for bit_unpacker; a second instance with MAX_REQ=12 covers length clamping.
module tb_bit_unpacker;

  logic        clock = 1'b0;
  logic        reset, pushin, reqin;
  logic [31:0] datain;
  logic [3:0]  reqlen;

  logic        reqbusy, pushout, fullout, overflow;
  logic [3:0]  lenout;
  logic [14:0] dataout;
  logic [10:0] bitcnt;

  logic        reqbusy12, pushout12, fullout12, overflow12;
  logic [3:0]  lenout12;
  logic [11:0] dataout12;
  logic [10:0] bitcnt12;

  int vectors = 0;
  int errors  = 0;

`ifdef BITS_MSB_FIRST_EN
  localparam logic [31:0] E_B4 = 32'hA, E_B8 = 32'h5A, E_S4 = 32'b1100, E_ABC = 32'h000;
  localparam logic [31:0] E_F15 = 32'h0787, E_C15 = 32'h091A, E_C12 = 32'h123;
`else
  localparam logic [31:0] E_B4 = 32'hF, E_B8 = 32'h00, E_S4 = 32'b0011, E_ABC = 32'hABC;
  localparam logic [31:0] E_F15 = 32'h5555, E_C15 = 32'h5678, E_C12 = 32'h678;
`endif

  always #5 clock = ~clock;

  bit_unpacker dut (
    .clock(clock), .reset(reset), .pushin(pushin), .datain(datain),
    .reqin(reqin), .reqlen(reqlen), .reqbusy(reqbusy), .pushout(pushout),
    .lenout(lenout), .dataout(dataout), .fullout(fullout), .bitcnt(bitcnt),
    .overflow(overflow)
  );

  bit_unpacker #(.MAX_REQ(12)) dut12 (
    .clock(clock), .reset(reset), .pushin(pushin), .datain(datain),
    .reqin(reqin), .reqlen(reqlen), .reqbusy(reqbusy12), .pushout(pushout12),
    .lenout(lenout12), .dataout(dataout12), .fullout(fullout12), .bitcnt(bitcnt12),
    .overflow(overflow12)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%0h expected=%0h", vectors, tag, obs, exp);
  endtask

  task automatic push_word(input logic [31:0] w);
    pushin = 1'b1;
    datain = w;
    tick();
    pushin = 1'b0;
  endtask

  task automatic req(input logic [3:0] len);
    reqin  = 1'b1;
    reqlen = len;
    tick();
    reqin  = 1'b0;
    tick();
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pushin = 1'b0; reqin = 1'b0; datain = '0; reqlen = '0;
    tick();
    tick();
    chk("rst_reqbusy", 32'(reqbusy), 32'd0);
    chk("rst_pushout", 32'(pushout), 32'd0);
    chk("rst_bitcnt", 32'(bitcnt), 32'd0);
    chk("rst_fullout", 32'(fullout), 32'd0);
    reset = 1'b0;

    // Basic extract, zero length, simultaneous push and service
    push_word(32'hA5A5_F00F);
    chk("basic_bitcnt0", 32'(bitcnt), 32'd32);
    req(4'd4);
    chk("basic4_pushout", 32'(pushout), 32'd1);
    chk("basic4_lenout", 32'(lenout), 32'd4);
    chk("basic4_data", 32'(dataout), E_B4);
    chk("basic4_bitcnt", 32'(bitcnt), 32'd28);
    req(4'd8);
    chk("basic8_lenout", 32'(lenout), 32'd8);
    chk("basic8_data", 32'(dataout), E_B8);
    chk("basic8_bitcnt", 32'(bitcnt), 32'd20);
    req(4'd0);
    chk("zero_pushout", 32'(pushout), 32'd1);
    chk("zero_lenout", 32'(lenout), 32'd0);
    chk("zero_data", 32'(dataout), 32'd0);
    chk("zero_bitcnt", 32'(bitcnt), 32'd20);
    reqin = 1'b1; reqlen = 4'd8;
    tick();
    reqin = 1'b0; pushin = 1'b1; datain = 32'h0000_0001;
    tick();
    pushin = 1'b0;
    chk("simul_pushout", 32'(pushout), 32'd1);
    chk("simul_data", 32'(dataout), 32'h5F);
    chk("simul_bitcnt", 32'(bitcnt), 32'd44);

    // Word straddle
    reset_pulse();
    push_word(32'hFFFF_FFFF);
    push_word(32'h0000_0000);
    req(4'd15);
    chk("strad1_data", 32'(dataout), 32'h7FFF);
    req(4'd15);
    chk("strad2_data", 32'(dataout), 32'h7FFF);
    req(4'd4);
    chk("strad3_data", 32'(dataout), E_S4);
    chk("strad3_bitcnt", 32'(bitcnt), 32'd30);

    // Starved wait
    reset_pulse();
    reqin = 1'b1; reqlen = 4'd12;
    tick();
    reqin = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("starve_reqbusy", 32'(reqbusy), 32'd1);
      chk("starve_pushout", 32'(pushout), 32'd0);
      tick();
    end
    push_word(32'h0000_0ABC);
    chk("starve_push_pushout", 32'(pushout), 32'd0);
    chk("starve_push_bitcnt", 32'(bitcnt), 32'd32);
    tick();
    chk("starve_srv_pushout", 32'(pushout), 32'd1);
    chk("starve_srv_data", 32'(dataout), E_ABC);
    chk("starve_srv_reqbusy", 32'(reqbusy), 32'd0);
    chk("starve_srv_bitcnt", 32'(bitcnt), 32'd20);
    tick();
    chk("hold_pushout", 32'(pushout), 32'd0);
    chk("hold_data", 32'(dataout), E_ABC);
    chk("hold_lenout", 32'(lenout), 32'd12);

    // Full and overflow
    reset_pulse();
    for (int i = 0; i < 33; i++) begin
      push_word(32'h0F0F_5555 ^ 32'(i));
      if (i == 30) chk("full31_fullout", 32'(fullout), 32'd0);
      if (i == 31) begin
        chk("full32_fullout", 32'(fullout), 32'd1);
        chk("full32_overflow", 32'(overflow), 32'd0);
      end
    end
    chk("full33_overflow", 32'(overflow), 32'd1);
    chk("full33_bitcnt", 32'(bitcnt), 32'd1024);
    req(4'd15);
    chk("fullr1_data", 32'(dataout), E_F15);
    chk("fullr1_fullout", 32'(fullout), 32'd1);
    req(4'd15);
    chk("fullr2_fullout", 32'(fullout), 32'd1);
    req(4'd15);
    chk("fullr3_fullout", 32'(fullout), 32'd0);
    chk("fullr3_bitcnt", 32'(bitcnt), 32'd979);
    chk("fullr3_overflow", 32'(overflow), 32'd1);

    // Clamp on the MAX_REQ=12 instance
    reset_pulse();
    chk("clamp_rst_overflow", 32'(overflow), 32'd0);
    push_word(32'h1234_5678);
    req(4'd15);
    chk("clamp15_lenout", 32'(lenout), 32'd15);
    chk("clamp15_data", 32'(dataout), E_C15);
    chk("clamp12_lenout", 32'(lenout12), 32'd12);
    chk("clamp12_data", 32'(dataout12), E_C12);
    chk("clamp12_bitcnt", 32'(bitcnt12), 32'd20);

    // Reset while a request waits
    reset_pulse();
    push_word(32'hDEAD_BEEF);
    reqin = 1'b1; reqlen = 4'd15;
    tick();
    reqin = 1'b0;
    chk("midrst_busy_before", 32'(reqbusy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_reqbusy", 32'(reqbusy), 32'd0);
    chk("midrst_pushout", 32'(pushout), 32'd0);
    chk("midrst_lenout", 32'(lenout), 32'd0);
    chk("midrst_dataout", 32'(dataout), 32'd0);
    chk("midrst_fullout", 32'(fullout), 32'd0);
    chk("midrst_bitcnt", 32'(bitcnt), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_no_pushout", 32'(pushout), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
